branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Branch target buffer / predictor serving the fetch stage. Fetch presents the current PC and receives a same-cycle taken/not-taken prediction, a predicted target and the 2-bit counter state. The EX stage resolves each branch and returns the outcome through the update port, which trains the buffer on the next rising edge. The block also keeps saturating statistics counters for lookups and mispredictions.

Parameters:
PC_W, 10, PC width (word-addressed; sequential PC = PC+1)
IDX_W, 4, index bits; 2**IDX_W direct-mapped entries
STAT_W, 16, width of statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
lookup_pc  input  PC_W  PC currently in fetch
hold  input  1  fetch stalled (load hazard); suppresses lookup counting only
pred_hit  output  1  valid entry with matching tag for lookup_pc
prediction  output  1  predicted taken
pred_target  output  PC_W  predicted target; 0 on miss
pred_state  output  2  counter state of hit entry; 2'b01 on miss
update_en  input  1  a resolved branch is in EX this cycle
update_pc  input  PC_W  PC of the resolved branch
update_taken  input  1  actual outcome
update_target  input  PC_W  actual branch target
update_mispredict  input  1  EX-detected misprediction (qualified by update_en)
stat_lookups  output  STAT_W  non-held lookup count
stat_mispredicts  output  STAT_W  misprediction count

Behaviour:
- idx = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W]. Each entry holds valid, tag, target (PC_W), and a 2-bit counter.
- Counter states: 0 = SNT, 1 = WNT, 2 = WT, 3 = ST. Taken increments and saturates at 3. Not-taken decrements and saturates at 0.
- Lookup is purely combinational with zero latency:
  - pred_hit = valid[idx] & (tag match).
  - prediction = pred_hit & state[1].
  - pred_target = hit ? target : 0.
  - pred_state = hit ? state : 2'b01.
- Update is registered at the posedge when update_en = 1:
  - hit & taken: increment the counter and write the target.
  - hit & not-taken: decrement the counter; the target is unchanged.
  - miss & taken: allocate or replace the entry: valid = 1, tag, target, state = WT (2).
  - miss & not-taken: no change.
- Same-cycle update and lookup to the same index: there is no bypass. The lookup returns pre-update contents, and the new contents are visible from the next cycle.
- update_en = 0: the other update inputs are ignored.
- Statistics:
  - stat_lookups increments each cycle that hold = 0.
  - stat_mispredicts increments when update_en & update_mispredict.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, at any time including mid-update):
  - All valid bits are cleared, all counters go to WNT, targets and tags go to 0, and statistics go to 0.
  - Outputs therefore read pred_hit = 0, prediction = 0, pred_target = 0, pred_state = 1.
  - An update coinciding with reset is dropped.
- Aliasing: a different tag at the same index is a miss. It replaces the entry only if taken.

Decomposition:
- Package bpu_pkg holds:
  - counter state localparams SNT/WNT/WT/ST;
  - the reset state WNT;
  - the function sat_next(state, taken) returning the next 2-bit state.
- One sub-module, btb_entry_array: storage of valid/tag/target/counter with an asynchronous read port, a synchronous write port and asynchronous reset.
- The top level holds the hit/allocate logic and the statistics counters.

Test Plan:
1. Assert rst mid-run after training, then release; lookup_pc = 10'h005 -> pred_hit = 0, prediction = 0, pred_target = 0, pred_state = 1, stats = 0.
2. Update pc = 10'h005, taken = 1, target = 10'h020; next cycle look up 10'h005 -> hit = 1, prediction = 1, target = 10'h020, state = 2.
3. Same entry, two updates taken -> state = 3 and stays 3; then three updates not-taken -> states 2, 1, 0, prediction 1, 0, 0, and 0 stays 0.
4. Miss with not-taken: update pc = 10'h033, taken = 0 -> lookup 10'h033 still misses. Alias: entry 10'h005 trained, update pc = 10'h015 (same idx) taken, target = 10'h040 -> lookup 10'h005 misses, 10'h015 hits with target 10'h040.
5. Same-cycle update and lookup of 10'h007, taken, target 10'h011 -> that cycle pred_hit = 0; next cycle hit, target 10'h011.
6. Statistics: 5 cycles with hold = 0 and 2 with hold = 1 -> stat_lookups = 5. With STAT_W = 4, 20 mispredict updates -> stat_mispredicts = 4'hF, no wrap.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter
// encodings, the reset state, and the saturating update function.
package bpu_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Counter value after reset and reported on a lookup miss
    localparam logic [1:0] CNT_RST = WNT;

    // Counter value given to a freshly allocated entry
    localparam logic [1:0] CNT_ALLOC = WT;

    function automatic logic [1:0] sat_next(
        input logic [1:0] state,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = state;
        if (taken) begin
            if (state != ST)
                nxt = state + 2'd1;
        end else begin
            if (state != SNT)
                nxt = state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_entry_array.sv
// Direct-mapped BTB storage: two asynchronous read ports (fetch
// lookup and EX update), one synchronous write port, async reset.
module btb_entry_array
    import bpu_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       i_lk_idx,
    output logic                   o_lk_valid,
    output logic [PC_W-IDX_W-1:0]  o_lk_tag,
    output logic [PC_W-1:0]        o_lk_target,
    output logic [1:0]             o_lk_state,
    input  logic [IDX_W-1:0]       i_up_idx,
    output logic                   o_up_valid,
    output logic [PC_W-IDX_W-1:0]  o_up_tag,
    output logic [PC_W-1:0]        o_up_target,
    output logic [1:0]             o_up_state,
    input  logic                   i_we,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic [PC_W-IDX_W-1:0]  i_wr_tag,
    input  logic [PC_W-1:0]        i_wr_target,
    input  logic [1:0]             i_wr_state
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [PC_W-1:0]  r_target [DEPTH];
    logic [1:0]       r_state  [DEPTH];

    assign o_lk_valid  = r_valid[i_lk_idx];
    assign o_lk_tag    = r_tag[i_lk_idx];
    assign o_lk_target = r_target[i_lk_idx];
    assign o_lk_state  = r_state[i_lk_idx];

    assign o_up_valid  = r_valid[i_up_idx];
    assign o_up_tag    = r_tag[i_up_idx];
    assign o_up_target = r_target[i_up_idx];
    assign o_up_state  = r_state[i_up_idx];

    // Entry storage: clear everything on reset, write one entry per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_state[i]  <= CNT_RST;
            end
        end else if (i_we) begin
            r_valid[i_wr_idx]  <= 1'b1;
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
            r_state[i_wr_idx]  <= i_wr_state;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Branch target buffer top: zero-latency fetch lookup, EX-driven
// training with allocate-on-taken, and saturating statistics.
module branch_target_buffer
    import bpu_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lookup_pc,
    input  logic              hold,
    output logic              pred_hit,
    output logic              prediction,
    output logic [PC_W-1:0]   pred_target,
    output logic [1:0]        pred_state,
    input  logic              update_en,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              update_taken,
    input  logic [PC_W-1:0]   update_target,
    input  logic              update_mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int TAG_W = PC_W - IDX_W;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_valid;
    logic [TAG_W-1:0] w_lk_etag;
    logic [PC_W-1:0]  w_lk_target;
    logic [1:0]       w_lk_state;
    logic             w_lk_hit;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_valid;
    logic [TAG_W-1:0] w_up_etag;
    logic [PC_W-1:0]  w_up_target;
    logic [1:0]       w_up_state;
    logic             w_up_hit;

    logic             w_we;
    logic [PC_W-1:0]  w_wr_target;
    logic [1:0]       w_wr_state;

    logic [STAT_W-1:0] r_lookups;
    logic [STAT_W-1:0] r_mispredicts;

    assign w_lk_idx = lookup_pc[IDX_W-1:0];
    assign w_lk_tag = lookup_pc[PC_W-1:IDX_W];
    assign w_up_idx = update_pc[IDX_W-1:0];
    assign w_up_tag = update_pc[PC_W-1:IDX_W];

    btb_entry_array #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_lk_idx    (w_lk_idx),
        .o_lk_valid  (w_lk_valid),
        .o_lk_tag    (w_lk_etag),
        .o_lk_target (w_lk_target),
        .o_lk_state  (w_lk_state),
        .i_up_idx    (w_up_idx),
        .o_up_valid  (w_up_valid),
        .o_up_tag    (w_up_etag),
        .o_up_target (w_up_target),
        .o_up_state  (w_up_state),
        .i_we        (w_we),
        .i_wr_idx    (w_up_idx),
        .i_wr_tag    (w_up_tag),
        .i_wr_target (w_wr_target),
        .i_wr_state  (w_wr_state)
    );

    assign w_lk_hit = w_lk_valid && (w_lk_etag == w_lk_tag);
    assign w_up_hit = w_up_valid && (w_up_etag == w_up_tag);

    assign pred_hit    = w_lk_hit;
    assign prediction  = w_lk_hit && w_lk_state[1];
    assign pred_target = w_lk_hit ? w_lk_target : '0;
    assign pred_state  = w_lk_hit ? w_lk_state : CNT_RST;

    // Training: hits update the counter, taken misses allocate
    always_comb begin
        w_we        = 1'b0;
        w_wr_target = w_up_target;
        w_wr_state  = w_up_state;
        if (update_en) begin
            if (w_up_hit) begin
                w_we       = 1'b1;
                w_wr_state = sat_next(w_up_state, update_taken);
                if (update_taken)
                    w_wr_target = update_target;
            end else if (update_taken) begin
                w_we        = 1'b1;
                w_wr_state  = CNT_ALLOC;
                w_wr_target = update_target;
            end
        end
    end

    // Statistics counters saturate at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lookups     <= '0;
            r_mispredicts <= '0;
        end else begin
            if (!hold && r_lookups != '1)
                r_lookups <= r_lookups + STAT_W'(1);
            if (update_en && update_mispredict && r_mispredicts != '1)
                r_mispredicts <= r_mispredicts + STAT_W'(1);
        end
    end

    assign stat_lookups     = r_lookups;
    assign stat_mispredicts = r_mispredicts;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed stimulus
// pushes expectations, a negedge monitor pops and compares.
module tb_branch_target_buffer;

    localparam int PC_W   = 10;
    localparam int IDX_W  = 4;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   lookup_pc;
    logic              hold;
    logic              pred_hit;
    logic              prediction;
    logic [PC_W-1:0]   pred_target;
    logic [1:0]        pred_state;
    logic              update_en;
    logic [PC_W-1:0]   update_pc;
    logic              update_taken;
    logic [PC_W-1:0]   update_target;
    logic              update_mispredict;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispredicts;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        bit          lk;
        logic        hit;
        logic        pred;
        logic [9:0]  tgt;
        logic [1:0]  st;
        bit          sl_en;
        logic [3:0]  sl;
        bit          sm_en;
        logic [3:0]  sm;
    } exp_t;

    exp_t sb[$];

    branch_target_buffer #(
        .PC_W   (PC_W),
        .IDX_W  (IDX_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc         (lookup_pc),
        .hold              (hold),
        .pred_hit          (pred_hit),
        .prediction        (prediction),
        .pred_target       (pred_target),
        .pred_state        (pred_state),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .stat_lookups      (stat_lookups),
        .stat_mispredicts  (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are stable at negedge; check all pending entries
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.lk) begin
                cmp(e.name, "hit", 16'(pred_hit), 16'(e.hit));
                cmp(e.name, "pred", 16'(prediction), 16'(e.pred));
                cmp(e.name, "tgt", 16'(pred_target), 16'(e.tgt));
                cmp(e.name, "st", 16'(pred_state), 16'(e.st));
            end
            if (e.sl_en)
                cmp(e.name, "lookups", 16'(stat_lookups), 16'(e.sl));
            if (e.sm_en)
                cmp(e.name, "mispred", 16'(stat_mispredicts), 16'(e.sm));
        end
    end

    task automatic drive(input logic [9:0] lpc, input logic hd,
                         input logic en, input logic [9:0] upc,
                         input logic tk, input logic [9:0] utg,
                         input logic mp);
        lookup_pc         = lpc;
        hold              = hd;
        update_en         = en;
        update_pc         = upc;
        update_taken      = tk;
        update_target     = utg;
        update_mispredict = mp;
    endtask

    task automatic exp_lk(input string n, input logic h, input logic p,
                          input logic [9:0] t, input logic [1:0] s);
        exp_t e;
        e = '{name: n, lk: 1'b1, hit: h, pred: p, tgt: t, st: s,
              sl_en: 1'b0, sl: 4'h0, sm_en: 1'b0, sm: 4'h0};
        sb.push_back(e);
    endtask

    task automatic exp_stats(input string n, input bit sle, input logic [3:0] sl,
                             input bit sme, input logic [3:0] sm);
        exp_t e;
        e = '{name: n, lk: 1'b0, hit: 1'b0, pred: 1'b0, tgt: 10'h0, st: 2'h0,
              sl_en: sle, sl: sl, sm_en: sme, sm: sm};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle with an update pending, release after an edge
    task automatic mid_reset();
        #3 rst = 1'b1;
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b1, 10'h3FF, 1'b1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        miscompares++;
        $display("FAIL timeout simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Train before the mid-run reset
        drive(10'h000, 1'b0, 1'b1, 10'h005, 1'b1, 10'h020, 1'b1);
        tick();
        drive(10'h005, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("pre_rst", 1'b1, 1'b1, 10'h020, 2'd2);
        tick();

        // 1: reset clears entries and stats; coinciding update dropped
        mid_reset();
        drive(10'h005, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("rst_lk", 1'b0, 1'b0, 10'h000, 2'd1);
        exp_stats("rst_stat", 1'b1, 4'h0, 1'b1, 4'h0);
        tick();

        // 2: allocate on taken miss
        drive(10'h000, 1'b1, 1'b1, 10'h005, 1'b1, 10'h020, 1'b0);
        exp_lk("alloc_other", 1'b0, 1'b0, 10'h000, 2'd1);
        tick();
        drive(10'h005, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("alloc_hit", 1'b1, 1'b1, 10'h020, 2'd2);
        tick();

        // 3: saturation up, then down
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b1, 10'h020, 1'b0);
        exp_lk("up1_pre", 1'b1, 1'b1, 10'h020, 2'd2);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b1, 10'h020, 1'b0);
        exp_lk("up2_pre", 1'b1, 1'b1, 10'h020, 2'd3);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b0, 10'h3AA, 1'b0);
        exp_lk("st_sat", 1'b1, 1'b1, 10'h020, 2'd3);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b0, 10'h3AA, 1'b0);
        exp_lk("dn_wt", 1'b1, 1'b1, 10'h020, 2'd2);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b0, 10'h3AA, 1'b0);
        exp_lk("dn_wnt", 1'b1, 1'b0, 10'h020, 2'd1);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h005, 1'b0, 10'h3AA, 1'b0);
        exp_lk("dn_snt", 1'b1, 1'b0, 10'h020, 2'd0);
        tick();
        drive(10'h005, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("snt_sat", 1'b1, 1'b0, 10'h020, 2'd0);
        tick();

        // 4: not-taken miss does not allocate; aliasing replaces on taken
        drive(10'h000, 1'b1, 1'b1, 10'h033, 1'b0, 10'h050, 1'b0);
        tick();
        drive(10'h033, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("nt_miss", 1'b0, 1'b0, 10'h000, 2'd1);
        tick();
        drive(10'h005, 1'b1, 1'b1, 10'h015, 1'b1, 10'h040, 1'b0);
        exp_lk("alias_pre", 1'b1, 1'b0, 10'h020, 2'd0);
        tick();
        drive(10'h005, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("alias_old", 1'b0, 1'b0, 10'h000, 2'd1);
        tick();
        drive(10'h015, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("alias_new", 1'b1, 1'b1, 10'h040, 2'd2);
        tick();

        // 5: no bypass for same-cycle update and lookup
        drive(10'h007, 1'b1, 1'b1, 10'h007, 1'b1, 10'h011, 1'b0);
        exp_lk("same_cyc", 1'b0, 1'b0, 10'h000, 2'd1);
        tick();
        drive(10'h007, 1'b1, 1'b0, 10'h007, 1'b0, 10'h2AA, 1'b1);
        exp_lk("next_cyc", 1'b1, 1'b1, 10'h011, 2'd2);
        tick();
        drive(10'h007, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_lk("en_low", 1'b1, 1'b1, 10'h011, 2'd2);
        exp_stats("en_low_st", 1'b0, 4'h0, 1'b1, 4'h0);
        tick();

        // 6: statistics
        mid_reset();
        begin
            logic hold_pat [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++) begin
                drive(10'h000, hold_pat[i], 1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
                tick();
            end
        end
        drive(10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_stats("lookups5", 1'b1, 4'h5, 1'b1, 4'h0);
        for (int i = 1; i <= 20; i++) begin
            drive(10'h3F0, 1'b0, 1'b1, 10'h3F0, 1'b0, 10'h000, 1'b1);
            tick();
            if (i == 14)
                exp_stats("misp14", 1'b1, 4'hF, 1'b1, 4'hE);
            if (i == 15)
                exp_stats("misp15", 1'b0, 4'h0, 1'b1, 4'hF);
        end
        drive(10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        exp_stats("sat_nowrap", 1'b1, 4'hF, 1'b1, 4'hF);
        tick();
        tick();

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain scoreboard has %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
